// File: rtl/prbs7_checker.sv
// RX-side PRBS7 (x^7+x^6+1) checker: self-synchronizes to the received stream,
// then free-runs a local LFSR, counts bit errors and re-acquires on dense errors.
module prbs7_checker #(
    parameter int unsigned NLOCK  = 16,
    parameter int unsigned WIN    = 128,
    parameter int unsigned ERR_TH = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             in,
    output logic             lock,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int unsigned SR_W   = 7;
    localparam int unsigned FILL_W = 3;
    localparam int unsigned ACQ_W  = $clog2(NLOCK + 1);
    localparam int unsigned WIN_W  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int unsigned WERR_W = $clog2(WIN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACQ  = 2'd1,
        LOCK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [ACQ_W-1:0]   acq_q, acq_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [WERR_W-1:0]  werr_q, werr_d;
    logic               lock_q, lock_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

    logic               pred_bit;
    logic               mis;
    logic [WERR_W-1:0]  werr_sum;

    // Recursion prediction from the 7-bit history; sr[6] is the oldest bit.
    assign pred_bit = sr_q[6] ^ sr_q[5];
    assign mis      = in ^ pred_bit;
    assign werr_sum = werr_q + WERR_W'(mis);

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            fill_q    <= '0;
            acq_q     <= '0;
            win_q     <= '0;
            werr_q    <= '0;
            lock_q    <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            acq_q     <= acq_d;
            win_q     <= win_d;
            werr_q    <= werr_d;
            lock_q    <= lock_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        fill_d    = fill_q;
        acq_d     = acq_q;
        win_d     = win_q;
        werr_d    = werr_q;
        lock_d    = lock_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        bit_cnt_d = bit_cnt_q;

        if (!en) begin
            state_d = IDLE;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQ;
                    fill_d  = '0;
                    acq_d   = '0;
                    lock_d  = 1'b0;
                end

                // Load received bits; predictions only count once the history is full.
                ACQ: begin
                    sr_d = {sr_q[5:0], in};
                    if (fill_q != FILL_W'(SR_W)) begin
                        fill_d = fill_q + FILL_W'(1);
                    end else if ((sr_q == '0) || mis) begin
                        acq_d = '0;
                    end else if (acq_q == ACQ_W'(NLOCK - 1)) begin
                        state_d = LOCK;
                        lock_d  = 1'b1;
                        acq_d   = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else begin
                        acq_d = acq_q + ACQ_W'(1);
                    end
                end

                // Free-run on the local prediction so a single flip costs one error.
                LOCK: begin
                    sr_d  = {sr_q[5:0], pred_bit};
                    err_d = mis;
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    if (mis && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (win_q == WIN_W'(WIN - 1)) begin
                        win_d  = '0;
                        werr_d = '0;
                        if (werr_sum >= WERR_W'(ERR_TH)) begin
                            state_d = ACQ;
                            lock_d  = 1'b0;
                            fill_d  = '0;
                            acq_d   = '0;
                        end
                    end else begin
                        win_d  = win_q + WIN_W'(1);
                        werr_d = werr_sum;
                    end
                end

                default: begin
                    state_d = IDLE;
                    lock_d  = 1'b0;
                end
            endcase
        end

        // Clear wins over any same-cycle increment.
        if (clr) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
        end
    end

    assign lock    = lock_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Scoreboard bench for prbs7_checker: a history-based reference model predicts every
// cycle's outputs for a 16-bit-counter and a 4-bit-counter instance sharing one stimulus.
module tb_prbs7_checker;

    localparam int NLOCK  = 16;
    localparam int WIN    = 128;
    localparam int ERR_TH = 8;
    localparam int MAX_L  = 65535;
    localparam int MAX_S  = 15;
    localparam int M_IDLE = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic clr = 1'b0;
    logic in_bit = 1'b0;

    logic        lock, err, lock_s, err_s;
    logic [15:0] err_cnt, bit_cnt;
    logic [3:0]  err_cnt_s, bit_cnt_s;

    always #5 clk = ~clk;

    prbs7_checker dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in(in_bit),
        .lock(lock), .err(err), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
    );

    prbs7_checker #(.CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in(in_bit),
        .lock(lock_s), .err(err_s), .err_cnt(err_cnt_s), .bit_cnt(bit_cnt_s)
    );

    typedef struct packed {
        logic        lock;
        logic        err;
        logic [15:0] ec;
        logic [15:0] bc;
        logic        lock_s;
        logic        err_s;
        logic [3:0]  ec_s;
        logic [3:0]  bc_s;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    int m_mode, run, locked_bits, win_errs, ec, bc, ec_s, bc_s;
    bit m_lock, m_err;
    bit rx_hist[$];
    bit pred[$];
    bit tx_hist[$];

    function automatic void model_reset();
        m_mode = M_IDLE; run = 0; locked_bits = 0; win_errs = 0;
        ec = 0; bc = 0; ec_s = 0; bc_s = 0; m_lock = 0; m_err = 0;
        rx_hist.delete(); pred.delete();
    endfunction

    function automatic void model_edge();
        bit exp_b, mis, zero;
        if (rst) begin
            model_reset();
            return;
        end
        m_err = 0;
        if (!en) begin
            m_mode = M_IDLE;
            m_lock = 0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_ACQ;
            rx_hist.delete();
            run = 0;
        end else if (m_mode == M_ACQ) begin
            if (rx_hist.size() == 7) begin
                exp_b = rx_hist[0] ^ rx_hist[1];
                zero = 1;
                foreach (rx_hist[k]) if (rx_hist[k]) zero = 0;
                run = (!zero && (in_bit == exp_b)) ? run + 1 : 0;
            end
            rx_hist.push_back(in_bit);
            if (rx_hist.size() > 7) void'(rx_hist.pop_front());
            if (run == NLOCK) begin
                m_mode = M_LOCK; m_lock = 1; pred = rx_hist;
                locked_bits = 0; win_errs = 0; run = 0;
            end
        end else begin
            exp_b = pred[0] ^ pred[1];
            mis = (in_bit != exp_b);
            m_err = mis;
            pred.push_back(exp_b);
            void'(pred.pop_front());
            if (bc < MAX_L) bc++;
            if (bc_s < MAX_S) bc_s++;
            if (mis && ec < MAX_L) ec++;
            if (mis && ec_s < MAX_S) ec_s++;
            win_errs += int'(mis);
            if ((locked_bits % WIN) == WIN - 1) begin
                if (win_errs >= ERR_TH) begin
                    m_mode = M_ACQ; m_lock = 0; rx_hist.delete(); run = 0;
                end
                win_errs = 0;
            end
            locked_bits++;
        end
        if (clr) begin
            ec = 0; bc = 0; ec_s = 0; bc_s = 0;
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.lock = m_lock; o.err = m_err; o.ec = 16'(ec); o.bc = 16'(bc);
        o.lock_s = m_lock; o.err_s = m_err; o.ec_s = 4'(ec_s); o.bc_s = 4'(bc_s);
        return o;
    endfunction

    // Transmit-side PRBS7 source, seeded with all ones.
    function automatic bit next_prbs();
        bit b;
        b = tx_hist[0] ^ tx_hist[1];
        tx_hist.push_back(b);
        void'(tx_hist.pop_front());
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic b);
        en = e; clr = c; in_bit = b;
        model_edge();
        exp_q.push_back(model_obs());
        @(negedge clk);
    endtask

    // Monitor: compare every clocked output against the scoreboard head.
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g = {lock, err, err_cnt, bit_cnt, lock_s, err_s, err_cnt_s, bit_cnt_s};
                n_checks++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL sb @%0t: got lock=%b err=%b ec=%0d bc=%0d lock_s=%b err_s=%b ec_s=%0d bc_s=%0d expected lock=%b err=%b ec=%0d bc=%0d lock_s=%b err_s=%b ec_s=%0d bc_s=%0d",
                             $time, g.lock, g.err, g.ec, g.bc, g.lock_s, g.err_s, g.ec_s, g.bc_s,
                             e.lock, e.err, e.ec, e.bc, e.lock_s, e.err_s, e.ec_s, e.bc_s);
                end
            end
        end
    end

    initial begin
        int  seen, fall_at, rise_at;
        bit  b;
        for (int k = 0; k < 7; k++) tx_hist.push_back(1'b1);
        model_reset();

        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("reset_lock", int'(lock), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);
        chk("reset_bit_cnt", int'(bit_cnt), 0);
        rst = 1'b0;

        // 1: clean acquisition then 1270 clean locked bits
        step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 1; i <= 23; i++) begin
            step(1'b1, 1'b0, next_prbs());
            if (i == 22) chk("t1_lock_before_23", int'(lock), 0);
        end
        chk("t1_lock_at_23", int'(lock), 1);
        for (int i = 0; i < 1270; i++) step(1'b1, 1'b0, next_prbs());
        chk("t1_err_cnt", int'(err_cnt), 0);
        chk("t1_bit_cnt", int'(bit_cnt), 1270);

        // 2: single flipped bit at index 500
        step(1'b1, 1'b1, next_prbs());
        chk("t2_clr_bit_cnt", int'(bit_cnt), 0);
        for (int i = 1; i <= 600; i++) begin
            b = next_prbs();
            step(1'b1, 1'b0, (i == 500) ? ~b : b);
            if (i == 499) chk("t2_err_before", int'(err), 0);
            if (i == 500) chk("t2_err_pulse", int'(err), 1);
            if (i == 501) chk("t2_err_after", int'(err), 0);
        end
        chk("t2_err_cnt", int'(err_cnt), 1);
        chk("t2_lock", int'(lock), 1);

        // 3: bit slip, lock falls at a window boundary and re-acquires
        void'(next_prbs());
        fall_at = -1; rise_at = -1;
        for (int i = 1; i <= 3 * WIN; i++) begin
            step(1'b1, 1'b0, next_prbs());
            if (fall_at < 0 && !lock) fall_at = i;
            else if (fall_at >= 0 && lock) begin rise_at = i; break; end
        end
        chk("t3_fell", int'(fall_at > 0 && fall_at <= 2 * WIN), 1);
        chk("t3_relock_gap", int'(rise_at > fall_at && rise_at - fall_at <= 23), 1);

        // 4: all-zero and inverted PRBS never lock
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (lock) seen = 1;
        end
        chk("t4_zero_lock", seen, 0);
        chk("t4_zero_err_cnt", int'(err_cnt), 0);
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, 1'b0, ~next_prbs());
            if (lock) seen = 1;
        end
        chk("t4_inv_lock", seen, 0);
        chk("t4_inv_err_cnt", int'(err_cnt), 0);

        // 5: error burst saturates the narrow counter, then clr beats a same-edge error
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, next_prbs());
            if (lock) begin seen = 1; break; end
        end
        chk("t5_locked", seen, 1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, ~next_prbs());
        chk("t5_sat_s", int'(err_cnt_s), 15);
        chk("t5_cnt_wide", int'(err_cnt), 20);
        step(1'b1, 1'b1, ~next_prbs());
        chk("t5_clr_err", int'(err), 1);
        chk("t5_clr_s", int'(err_cnt_s), 0);
        chk("t5_clr_wide", int'(err_cnt), 0);

        // 6: async reset mid-LOCK, then re-lock on bit 23
        fall_at = -1; rise_at = -1;
        for (int i = 1; i <= 3 * WIN; i++) begin
            step(1'b1, 1'b0, next_prbs());
            if (fall_at < 0 && !lock) fall_at = i;
            else if (fall_at >= 0 && lock) begin rise_at = i; break; end
        end
        chk("t6_relocked", int'(rise_at > 0), 1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, next_prbs());
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("t6_rst_lock", int'(lock), 0);
        chk("t6_rst_bit_cnt", int'(bit_cnt), 0);
        chk("t6_rst_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        for (int i = 1; i <= 23; i++) begin
            step(1'b1, 1'b0, next_prbs());
            if (i == 22) chk("t6_lock_before_23", int'(lock), 0);
        end
        chk("t6_lock_at_23", int'(lock), 1);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, $urandom_range(0, 9) == 0 ? ~next_prbs() : next_prbs());

        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
